// File: rtl/fp_writeback_scoreboard_if.sv
// Bundle between FP issue logic, the FPU/LSU writeback paths and the FP register file.
// The slave side is the writeback scoreboard; the master side drives its requests.
interface fp_writeback_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic                  fpu_valid;
    logic [ADDR_WIDTH-1:0] fpu_addr;
    logic [DATA_WIDTH-1:0] fpu_data;
    logic                  fpu_ready;

    logic                  lsu_valid;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  lsu_ready;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic [ADDR_WIDTH-1:0] issue_rs1;
    logic [ADDR_WIDTH-1:0] issue_rs2;
    logic [ADDR_WIDTH-1:0] issue_rs3;
    logic [2:0]            issue_use_rs;
    logic                  issue_stall;

    logic                  rf_write_En;
    logic [ADDR_WIDTH-1:0] rf_writeAddr;
    logic [DATA_WIDTH-1:0] rf_data_in;
    logic [NUM_REGS-1:0]   busy_vec;

    modport slave (
        input  fpu_valid, fpu_addr, fpu_data,
        output fpu_ready,
        input  lsu_valid, lsu_addr, lsu_data,
        output lsu_ready,
        input  issue_valid, issue_rd, issue_rs1, issue_rs2, issue_rs3, issue_use_rs,
        output issue_stall,
        output rf_write_En, rf_writeAddr, rf_data_in, busy_vec
    );

    modport master (
        output fpu_valid, fpu_addr, fpu_data,
        input  fpu_ready,
        output lsu_valid, lsu_addr, lsu_data,
        input  lsu_ready,
        output issue_valid, issue_rd, issue_rs1, issue_rs2, issue_rs3, issue_use_rs,
        input  issue_stall,
        input  rf_write_En, rf_writeAddr, rf_data_in, busy_vec
    );
endinterface

// File: rtl/fp_writeback_scoreboard.sv
// Single FP register-file write port shared round-robin by FPU results and FLW loads,
// plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module fp_writeback_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    fp_writeback_scoreboard_if.slave  wb
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic {
        RR_FPU = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    rr_e                   rr_q, rr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic                  grant_fpu_s;
    logic                  grant_lsu_s;
    logic                  hazard_s;
    logic                  stall_s;
    logic [NUM_REGS-1:0]   set_vec_s;
    logic [NUM_REGS-1:0]   clr_vec_s;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin arbitration; the pointer only moves while both sides contend.
    always_comb begin
        grant_fpu_s = 1'b0;
        grant_lsu_s = 1'b0;
        rr_d        = rr_q;
        case ({wb.fpu_valid, wb.lsu_valid})
            2'b11: begin
                if (rr_q == RR_FPU) begin
                    grant_fpu_s = 1'b1;
                    rr_d        = RR_LSU;
                end else begin
                    grant_lsu_s = 1'b1;
                    rr_d        = RR_FPU;
                end
            end
            2'b10:   grant_fpu_s = 1'b1;
            2'b01:   grant_lsu_s = 1'b1;
            default: begin
                grant_fpu_s = 1'b0;
                grant_lsu_s = 1'b0;
            end
        endcase
    end

    // Next contents of the registered write port; address/data hold when idle.
    always_comb begin
        wr_en_d   = grant_fpu_s | grant_lsu_s;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_fpu_s) begin
            wr_addr_d = wb.fpu_addr;
            wr_data_d = wb.fpu_data;
        end else if (grant_lsu_s) begin
            wr_addr_d = wb.lsu_addr;
            wr_data_d = wb.lsu_data;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // Hazard detection straight from the registered busy bits (no forwarding).
    always_comb begin
        hazard_s = busy_q[wb.issue_rd]
                 | (wb.issue_use_rs[0] & busy_q[wb.issue_rs1])
                 | (wb.issue_use_rs[1] & busy_q[wb.issue_rs2])
                 | (wb.issue_use_rs[2] & busy_q[wb.issue_rs3]);
        stall_s  = wb.issue_valid & hazard_s;
    end

    // Busy update: the committing write clears, an accepted issue sets, and set wins.
    always_comb begin
        set_vec_s = '0;
        clr_vec_s = '0;
        if (wb.issue_valid && !stall_s) begin
            set_vec_s = reg_onehot(wb.issue_rd);
        end else begin
            set_vec_s = '0;
        end
        if (wr_en_q) begin
            clr_vec_s = reg_onehot(wr_addr_q);
        end else begin
            clr_vec_s = '0;
        end
        busy_d = (busy_q & ~clr_vec_s) | set_vec_s;
    end

    // State registers; reset drops any in-flight write and clears the scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= RR_FPU;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb.fpu_ready    = grant_fpu_s;
    assign wb.lsu_ready    = grant_lsu_s;
    assign wb.issue_stall  = stall_s;
    assign wb.rf_write_En  = wr_en_q;
    assign wb.rf_writeAddr = wr_addr_q;
    assign wb.rf_data_in   = wr_data_q;
    assign wb.busy_vec     = busy_q;

endmodule
